// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC high-voltage sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_G1_RAMP  = 3'd1,
    S_AN_RAMP  = 3'd2,
    S_RUN      = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } seq_state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_G1_ALM  = 3'd1;
  localparam logic [2:0] FC_AN_ALM  = 3'd2;
  localparam logic [2:0] FC_G1_TMO  = 3'd3;
  localparam logic [2:0] FC_AN_FLT  = 3'd4;
  localparam logic [2:0] FC_AN_NRDY = 3'd5;

  // Cycle counts at the 1.28 us system clock
  localparam int unsigned CYC_0P5S = 390625;
  localparam int unsigned CYC_1S   = 781250;
  localparam int unsigned CYC_2S   = 1562500;
  localparam int unsigned CYC_3S   = 2343750;
  localparam int unsigned CYC_4S   = 3125000;

endpackage

// File: rtl/rpsc_seq_timer.sv
// Loadable down-counter that holds at zero; expired pulses while the count is 1.
module rpsc_seq_timer #(
  parameter int unsigned TW = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = (cnt == TW'(1)) & ~load;

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// G1/anode HV power sequencer with first-fault latch.
// Optional saturating fault counter enabled by defining RPSC_SEQ_FAULT_CNT_EN.
module rpsc_hv_sequencer
  import rpsc_pkg::*;
#(
  parameter int unsigned G1_TMO    = CYC_3S,
  parameter int unsigned AN_SETTLE = CYC_1S,
  parameter int unsigned DISCH     = CYC_0P5S,
  parameter int unsigned TW        = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clr,
  input  logic       g1_not_alarm,
  input  logic       g1_not_ok,
  input  logic       an_not_alarm,
  input  logic       an_th_ready_n,
  input  logic       an_not_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic       running,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state,
  output logic [7:0] fault_cnt
);

  seq_state_t    st, nxt;
  logic          alarm, active, go_up, g1_adv, stop_go;
  logic          tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;
  logic [2:0]    alm_code, code_d;

  assign alarm    = ~g1_not_alarm | ~an_not_alarm;
  assign alm_code = g1_not_alarm ? FC_AN_ALM : FC_G1_ALM;
  assign active   = (st == S_G1_RAMP) || (st == S_AN_RAMP) || (st == S_RUN);

  // Timer loads are decoded from state and inputs only, keeping expiry out of the load path
  assign go_up    = (st == S_IDLE) & start_req & ~stop_req & ~alarm;
  assign g1_adv   = (st == S_G1_RAMP) & ~alarm & ~stop_req & ~g1_not_ok;
  assign stop_go  = active & ~alarm & stop_req;
  assign tmr_load = go_up | g1_adv | stop_go;
  assign tmr_val  = go_up ? TW'(G1_TMO) : (g1_adv ? TW'(AN_SETTLE) : TW'(DISCH));

  rpsc_seq_timer #(.TW(TW)) u_tmr (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  always_comb begin
    nxt    = st;
    code_d = FC_NONE;
    unique case (st)
      S_IDLE: if (go_up) nxt = S_G1_RAMP;
      S_G1_RAMP: begin
        if (alarm) begin
          nxt = S_FAULT; code_d = alm_code;
        end else if (stop_req) nxt = S_SHUTDOWN;
        else if (!g1_not_ok) nxt = S_AN_RAMP;
        else if (tmr_exp) begin
          nxt = S_FAULT; code_d = FC_G1_TMO;
        end
      end
      S_AN_RAMP: begin
        if (alarm) begin
          nxt = S_FAULT; code_d = alm_code;
        end else if (stop_req) nxt = S_SHUTDOWN;
        else if (an_not_ok) begin
          nxt = S_FAULT; code_d = FC_AN_FLT;
        end else if (tmr_exp) begin
          if (!an_th_ready_n) nxt = S_RUN;
          else begin
            nxt = S_FAULT; code_d = FC_AN_NRDY;
          end
        end
      end
      S_RUN: begin
        if (alarm) begin
          nxt = S_FAULT; code_d = alm_code;
        end else if (stop_req) nxt = S_SHUTDOWN;
        else if (an_not_ok) begin
          nxt = S_FAULT; code_d = FC_AN_FLT;
        end
      end
      S_SHUTDOWN: begin
        if (alarm) begin
          nxt = S_FAULT; code_d = alm_code;
        end else if (tmr_exp) nxt = S_IDLE;
      end
      S_FAULT: if (fault_clr && !alarm) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      g1_ps_act  <= 1'b0;
      an_ps_act  <= 1'b0;
      running    <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      st        <= nxt;
      g1_ps_act <= nxt inside {S_G1_RAMP, S_AN_RAMP, S_RUN, S_SHUTDOWN};
      an_ps_act <= nxt inside {S_AN_RAMP, S_RUN};
      running   <= (nxt == S_RUN);
      fault     <= (nxt == S_FAULT);
      if (nxt == S_FAULT && st != S_FAULT) fault_code <= code_d;
      else if (st == S_FAULT && nxt == S_IDLE) fault_code <= FC_NONE;
    end
  end

  assign state = st;

`ifdef RPSC_SEQ_FAULT_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else if (nxt == S_FAULT && st != S_FAULT && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign fault_cnt = cnt_q;
`else
  assign fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Directed scoreboard bench for rpsc_hv_sequencer with shortened timer constants.
module tb_rpsc_hv_sequencer;
  import rpsc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_req = 1'b0, stop_req = 1'b0, fault_clr = 1'b0;
  logic       g1_not_alarm = 1'b1, g1_not_ok = 1'b1;
  logic       an_not_alarm = 1'b1, an_th_ready_n = 1'b0, an_not_ok = 1'b0;
  logic       g1_ps_act, an_ps_act, running, fault;
  logic [2:0] fault_code, state;
  logic [7:0] fault_cnt;

`ifdef RPSC_SEQ_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rpsc_hv_sequencer #(
    .G1_TMO(20), .AN_SETTLE(10), .DISCH(8), .TW(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .fault_clr     (fault_clr),
    .g1_not_alarm  (g1_not_alarm),
    .g1_not_ok     (g1_not_ok),
    .an_not_alarm  (an_not_alarm),
    .an_th_ready_n (an_th_ready_n),
    .an_not_ok     (an_not_ok),
    .g1_ps_act     (g1_ps_act),
    .an_ps_act     (an_ps_act),
    .running       (running),
    .fault         (fault),
    .fault_code    (fault_code),
    .state         (state),
    .fault_cnt     (fault_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_out(input string tag, input logic g1, input logic an, input logic run,
                         input logic flt, input logic [2:0] code, input logic [2:0] st);
    push({tag, ".g1_ps_act"}, 32'(g1));
    push({tag, ".an_ps_act"}, 32'(an));
    push({tag, ".running"},   32'(run));
    push({tag, ".fault"},     32'(flt));
    push({tag, ".fault_code"}, 32'(code));
    push({tag, ".state"},     32'(st));
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_out();
    chk(32'(g1_ps_act));
    chk(32'(an_ps_act));
    chk(32'(running));
    chk(32'(fault));
    chk(32'(fault_code));
    chk(32'(state));
  endtask

  task automatic chk_cnt(input string tag, input int v);
    push({tag, ".fault_cnt"}, CNT_EN ? 32'(v) : 32'd0);
    chk(32'(fault_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    exp_out("rst", 0, 0, 0, 0, FC_NONE, S_IDLE); chk_out();
    chk_cnt("rst", 0);
    @(negedge clk); reset = 1'b1;
    tick(1);

    // 1. Normal power-up
    start_req = 1'b1;
    exp_out("t1_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    exp_out("t1_g1wait", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(4); chk_out();
    g1_not_ok = 1'b0;
    exp_out("t1_anon", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(1); chk_out();
    exp_out("t1_settle", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(9); chk_out();
    exp_out("t1_run", 1, 1, 1, 0, FC_NONE, S_RUN); tick(1); chk_out();

    // 2. Shutdown from RUN; start+stop both held keeps IDLE
    stop_req = 1'b1;
    exp_out("t2_anoff", 1, 0, 0, 0, FC_NONE, S_SHUTDOWN); tick(1); chk_out();
    exp_out("t2_disch", 1, 0, 0, 0, FC_NONE, S_SHUTDOWN); tick(7); chk_out();
    exp_out("t2_g1off", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(1); chk_out();
    exp_out("t2_hold", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(2); chk_out();
    start_req = 1'b0; stop_req = 1'b0; g1_not_ok = 1'b1;
    tick(1);

    // 3. G1 timeout
    start_req = 1'b1;
    exp_out("t3_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    start_req = 1'b0;
    exp_out("t3_last", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(19); chk_out();
    exp_out("t3_tmo", 0, 0, 0, 1, FC_G1_TMO, S_FAULT); tick(1); chk_out();
    chk_cnt("t3", 1);
    fault_clr = 1'b1;
    exp_out("t3_clr", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(1); chk_out();
    fault_clr = 1'b0;

    // 4. Alarm beats stop in AN_RAMP; clear blocked while alarm held
    start_req = 1'b1;
    exp_out("t4_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    g1_not_ok = 1'b0; start_req = 1'b0;
    exp_out("t4_anon", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(1); chk_out();
    g1_not_alarm = 1'b0; stop_req = 1'b1;
    exp_out("t4_alm", 0, 0, 0, 1, FC_G1_ALM, S_FAULT); tick(1); chk_out();
    stop_req = 1'b0; fault_clr = 1'b1;
    exp_out("t4_clrblk", 0, 0, 0, 1, FC_G1_ALM, S_FAULT); tick(2); chk_out();
    g1_not_alarm = 1'b1;
    exp_out("t4_clr", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(1); chk_out();
    fault_clr = 1'b0; g1_not_ok = 1'b1;
    chk_cnt("t4", 2);

    // Start refused while an anode alarm is present
    an_not_alarm = 1'b0; start_req = 1'b1;
    exp_out("t4_almidle", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(2); chk_out();
    an_not_alarm = 1'b1;

    // 5. Anode fault in RUN
    exp_out("t5_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    g1_not_ok = 1'b0;
    exp_out("t5_anon", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(1); chk_out();
    exp_out("t5_run", 1, 1, 1, 0, FC_NONE, S_RUN); tick(10); chk_out();
    an_not_ok = 1'b1;
    exp_out("t5_anflt", 0, 0, 0, 1, FC_AN_FLT, S_FAULT); tick(1); chk_out();
    chk_cnt("t5", 3);
    an_not_ok = 1'b0; start_req = 1'b0; fault_clr = 1'b1;
    exp_out("t5_clr", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(1); chk_out();
    fault_clr = 1'b0; g1_not_ok = 1'b1;

    // 6. Asynchronous reset mid AN_RAMP
    start_req = 1'b1;
    exp_out("t6_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    g1_not_ok = 1'b0;
    exp_out("t6_anon", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(3); chk_out();
    #2 reset = 1'b0; start_req = 1'b0;
    #1;
    exp_out("t6_async", 0, 0, 0, 0, FC_NONE, S_IDLE); chk_out();
    chk_cnt("t6_rst", 0);
    @(negedge clk); reset = 1'b1;
    exp_out("t6_norestart", 0, 0, 0, 0, FC_NONE, S_IDLE); tick(3); chk_out();

    // Anode permit not ready at settle expiry
    an_th_ready_n = 1'b1; start_req = 1'b1;
    exp_out("t7_g1on", 1, 0, 0, 0, FC_NONE, S_G1_RAMP); tick(1); chk_out();
    start_req = 1'b0;
    exp_out("t7_anon", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(1); chk_out();
    exp_out("t7_settle", 1, 1, 0, 0, FC_NONE, S_AN_RAMP); tick(9); chk_out();
    exp_out("t7_nrdy", 0, 0, 0, 1, FC_AN_NRDY, S_FAULT); tick(1); chk_out();
    chk_cnt("t7", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
